// File: rtl/mandel_iterator.sv
// rtl/mandel_iterator.sv - Mandelbrot escape-time iterator, z <- z^2 + c on signed Q(INT_BITS).(FRAC_BITS).
// Optional MANDEL_ESCAPE_Z_EN adds out_zr/out_zi carrying the final z for smooth shading.
module pipeline_mult #(
   parameter int W = 18
) (
   input  logic                  clock,
   input  logic                  rst,
   input  logic signed [W-1:0]   a,
   input  logic signed [W-1:0]   b,
   output logic signed [2*W-1:0] p
);
   logic signed [W-1:0] a_q;
   logic signed [W-1:0] b_q;

   always_ff @(posedge clock) begin
      if (rst) begin
         a_q <= '0;
         b_q <= '0;
         p   <= '0;
      end else begin
         a_q <= a;
         b_q <= b;
         p   <= a_q * b_q;
      end
   end
endmodule

module mandel_iterator #(
   parameter int INT_BITS  = 3,
   parameter int FRAC_BITS = 15,
   parameter int ITER_BITS = 10,
   parameter int MAX_ITER  = 1000,
   localparam int NUM_BITS = INT_BITS + FRAC_BITS
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic signed [NUM_BITS-1:0] c_re,
   input  logic signed [NUM_BITS-1:0] c_im,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [ITER_BITS-1:0]       out_iter
`ifdef MANDEL_ESCAPE_Z_EN
   ,
   output logic signed [NUM_BITS-1:0] out_zr,
   output logic signed [NUM_BITS-1:0] out_zi
`endif
);
   localparam int PW = 2 * NUM_BITS;
   localparam int SW = NUM_BITS + 1;
   localparam int UW = NUM_BITS + 2;
   localparam logic signed [NUM_BITS-1:0] TWO     = NUM_BITS'(1 << (FRAC_BITS + 1));
   localparam logic signed [SW-1:0]       FOUR_SQ = SW'(1 << (FRAC_BITS + 2));
   localparam logic signed [UW-1:0]       SAT_MAX = UW'((1 << (NUM_BITS - 1)) - 1);
   localparam logic signed [UW-1:0]       SAT_MIN = UW'(-(1 << (NUM_BITS - 1)));
   localparam logic [ITER_BITS-1:0]       MAX_CNT = ITER_BITS'(MAX_ITER);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, UPDATE, DONE} state_t;
   state_t state;

   logic signed [NUM_BITS-1:0] zr, zi, cr, ci;
   logic [ITER_BITS-1:0]       iter;
   logic signed [PW-1:0]       p_rr, p_ii, p_ri;
   logic signed [SW-1:0]       sq_r, sq_i, mag;
   logic signed [UW-1:0]       x2, nr, ni;
   logic signed [NUM_BITS-1:0] nr_sat, ni_sat;
   logic                       escape;
   logic                       mult_rst;
   logic                       unused_bits;

   assign mult_rst = ~reset;

   pipeline_mult #(.W(NUM_BITS)) u_mult_rr (.clock(clock), .rst(mult_rst), .a(zr), .b(zr), .p(p_rr));
   pipeline_mult #(.W(NUM_BITS)) u_mult_ii (.clock(clock), .rst(mult_rst), .a(zi), .b(zi), .p(p_ii));
   pipeline_mult #(.W(NUM_BITS)) u_mult_ri (.clock(clock), .rst(mult_rst), .a(zr), .b(zi), .p(p_ri));

   assign unused_bits = ^{p_rr[PW-1:FRAC_BITS+SW], p_rr[FRAC_BITS-1:0],
                          p_ii[PW-1:FRAC_BITS+SW], p_ii[FRAC_BITS-1:0],
                          p_ri[PW-1:FRAC_BITS-1+UW], p_ri[FRAC_BITS-2:0]};

   function automatic logic signed [NUM_BITS-1:0] sat(input logic signed [UW-1:0] v);
      if (v > SAT_MAX)
         return SAT_MAX[NUM_BITS-1:0];
      else if (v < SAT_MIN)
         return SAT_MIN[NUM_BITS-1:0];
      else
         return v[NUM_BITS-1:0];
   endfunction

   // Taking the cross product one bit lower yields 2*zr*zi without losing its LSB.
   always_comb begin
      sq_r   = p_rr[FRAC_BITS +: SW];
      sq_i   = p_ii[FRAC_BITS +: SW];
      x2     = p_ri[FRAC_BITS-1 +: UW];
      mag    = sq_r + sq_i;
      escape = (zr >= TWO) || (zr <= -TWO) || (zi >= TWO) || (zi <= -TWO) || (mag >= FOUR_SQ);
      nr     = UW'(sq_r) - UW'(sq_i) + UW'(cr);
      ni     = x2 + UW'(ci);
      nr_sat = sat(nr);
      ni_sat = sat(ni);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         out_iter  <= '0;
         zr        <= '0;
         zi        <= '0;
         cr        <= '0;
         ci        <= '0;
         iter      <= '0;
`ifdef MANDEL_ESCAPE_Z_EN
         out_zr    <= '0;
         out_zi    <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               in_ready <= 1'b1;
               if (in_valid && in_ready) begin
                  cr       <= c_re;
                  ci       <= c_im;
                  zr       <= '0;
                  zi       <= '0;
                  iter     <= '0;
                  in_ready <= 1'b0;
                  state    <= ISSUE;
               end
            end
            ISSUE: state <= WAIT;
            WAIT:  state <= UPDATE;
            UPDATE: begin
               // On the iteration limit iter already equals MAX_ITER, so both exits report iter.
               if (escape || (iter == MAX_CNT)) begin
                  out_iter  <= iter;
                  out_valid <= 1'b1;
`ifdef MANDEL_ESCAPE_Z_EN
                  out_zr    <= zr;
                  out_zi    <= zi;
`endif
                  state     <= DONE;
               end else begin
                  zr    <= nr_sat;
                  zi    <= ni_sat;
                  iter  <= iter + 1'b1;
                  state <= ISSUE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mandel_iterator.sv
// tb/tb_mandel_iterator.sv - self-checking bench for mandel_iterator
// Table vectors plus scoreboard; hand sequences cover reset, backpressure and mid-iteration abort.
`timescale 1ns/1ps
module tb_mandel_iterator;
   localparam int NB  = 18;
   localparam int FB  = 15;
   localparam int IB  = 10;
   localparam int MI  = 16;
   localparam int ONE = 1 << FB;

   logic                 clock     = 1'b0;
   logic                 reset     = 1'b0;
   logic                 in_valid  = 1'b0;
   logic                 out_ready = 1'b0;
   logic signed [NB-1:0] c_re      = '0;
   logic signed [NB-1:0] c_im      = '0;
   logic                 in_ready;
   logic                 out_valid;
   logic [IB-1:0]        out_iter;
`ifdef MANDEL_ESCAPE_Z_EN
   logic signed [NB-1:0] out_zr;
   logic signed [NB-1:0] out_zi;
`endif

   int total = 0;
   int bad   = 0;

   typedef struct { int iter; int zr; int zi; } exp_t;
   typedef struct { int cr; int ci; int iter; } vec_t;
   exp_t sb[$];
   vec_t vecs[10];

   always #5 clock = ~clock;

   mandel_iterator #(.INT_BITS(3), .FRAC_BITS(FB), .ITER_BITS(IB), .MAX_ITER(MI)) dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .c_re      (c_re),
      .c_im      (c_im),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_iter  (out_iter)
`ifdef MANDEL_ESCAPE_Z_EN
      ,
      .out_zr    (out_zr),
      .out_zi    (out_zi)
`endif
   );

   task automatic check(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Real-valued escape-time reference on scaled integers, floor rounding on products.
   function automatic exp_t model(input int cr, input int ci);
      longint zr = 0, zi = 0, sr, si, nr, ni;
      longint two = 2 * ONE, four = 4 * ONE;
      longint smax = (1 << (NB - 1)) - 1, smin = -(1 << (NB - 1));
      int it = 0;
      bit done = 1'b0;
      exp_t e;
      while (!done) begin
         if (zr >= two || zr <= -two || zi >= two || zi <= -two) begin
            done = 1'b1;
         end else begin
            sr = (zr * zr) >>> FB;
            si = (zi * zi) >>> FB;
            if (sr + si >= four || it == MI) begin
               done = 1'b1;
            end else begin
               nr = sr - si + cr;
               ni = ((2 * zr * zi) >>> FB) + ci;
               zr = (nr > smax) ? smax : ((nr < smin) ? smin : nr);
               zi = (ni > smax) ? smax : ((ni < smin) ? smin : ni);
               it++;
            end
         end
      end
      e.iter = it;
      e.zr   = int'(zr);
      e.zi   = int'(zi);
      return e;
   endfunction

   task automatic send(input string tag, input int cr, input int ci, input int exp_iter);
      exp_t e;
      int   n = 0;
      while (!in_ready && n < 200) begin
         @(posedge clock);
         #1;
         n++;
      end
      check({tag, "_in_ready"}, in_ready, 1);
      c_re     = NB'(cr);
      c_im     = NB'(ci);
      in_valid = 1'b1;
      @(posedge clock);
      e = model(cr, ci);
      if (exp_iter >= 0) e.iter = exp_iter;
      sb.push_back(e);
      #1 in_valid = 1'b0;
   endtask

   task automatic collect(input string tag, input bit release_now);
      exp_t e;
      int   n = 0;
      while (!out_valid && n < 5000) begin
         @(posedge clock);
         #1;
         n++;
      end
      check({tag, "_out_valid"}, out_valid, 1);
      if (sb.size() == 0) begin
         total++;
         bad++;
         $display("FAIL %s_scoreboard: got empty expected one entry", tag);
         return;
      end
      e = sb.pop_front();
      check({tag, "_iter"}, out_iter, e.iter);
      check({tag, "_latency"}, n, 3 * (e.iter + 1));
`ifdef MANDEL_ESCAPE_Z_EN
      check({tag, "_zr"}, out_zr, e.zr);
      check({tag, "_zi"}, out_zi, e.zi);
`endif
      if (release_now) begin
         out_ready = 1'b1;
         @(posedge clock);
         #1 out_ready = 1'b0;
         check({tag, "_released"}, out_valid, 0);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int seen;

      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         in_valid  = 1'($urandom);
         out_ready = 1'($urandom);
         c_re      = NB'($urandom);
         c_im      = NB'($urandom);
         @(posedge clock);
         #1;
         check("rst_in_ready", in_ready, 0);
         check("rst_out_valid", out_valid, 0);
         check("rst_out_iter", out_iter, 0);
      end
      @(negedge clock);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      reset     = 1'b1;
      #1 check("rel_in_ready_before_edge", in_ready, 0);
      @(posedge clock);
      #1 check("rel_in_ready_after_edge", in_ready, 1);

      vecs = '{'{0, 0, 16}, '{ONE, 0, 2}, '{-2 * ONE, 0, 1}, '{0, ONE, 16},
               '{-ONE, 0, 16}, '{49152, 49152, 1}, '{62259, 0, 2}, '{114688, 0, 1},
               '{-24576, 3277, -1}, '{9830, 19661, -1}};
      foreach (vecs[i]) begin
         send($sformatf("vec%0d", i), vecs[i].cr, vecs[i].ci, vecs[i].iter);
         collect($sformatf("vec%0d", i), 1'b1);
      end

      for (int i = 0; i < 4; i++) begin
         int rr, ri;
         rr = int'($urandom_range(4 * ONE - 1, 0)) - 2 * ONE;
         ri = int'($urandom_range(4 * ONE - 1, 0)) - 2 * ONE;
         send($sformatf("rnd%0d", i), rr, ri, -1);
         collect($sformatf("rnd%0d", i), 1'b1);
      end

      send("bp", ONE, 0, 2);
      collect("bp", 1'b0);
      c_re     = NB'(-2 * ONE);
      c_im     = '0;
      in_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clock);
         #1;
         check("bp_hold_valid", out_valid, 1);
         check("bp_hold_iter", out_iter, 2);
         check("bp_hold_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      @(posedge clock);
      #1 out_ready = 1'b0;
      check("bp_release_valid", out_valid, 0);
      check("bp_release_in_ready", in_ready, 1);
      @(posedge clock);
      sb.push_back(model(-2 * ONE, 0));
      #1 in_valid = 1'b0;
      check("bp_second_accepted", in_ready, 0);
      collect("bp2", 1'b1);

      send("abort", 0, 0, 16);
      @(posedge clock);
      #1 reset = 1'b0;
      sb.delete();
      for (int i = 0; i < 4; i++) begin
         @(posedge clock);
         #1;
         check("abort_rst_valid", out_valid, 0);
         check("abort_rst_in_ready", in_ready, 0);
      end
      @(negedge clock);
      reset = 1'b1;
      seen  = 0;
      for (int i = 0; i < 60; i++) begin
         @(posedge clock);
         #1;
         if (out_valid) seen++;
      end
      check("abort_no_result", seen, 0);
      send("post_rst", ONE, 0, 2);
      collect("post_rst", 1'b1);

      check("sb_drained", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
